// File: rtl/uart_tx_buffer_if.sv
// CPU-side UART write port: push strobe, data byte and registered ready.
interface uart_tx_buffer_if;
  logic       uartWriteReq;
  logic [7:0] uartWriteData;
  logic       uartWriteReady;

  // Producer side (CPU control unit)
  modport master (
    output uartWriteReq,
    output uartWriteData,
    input  uartWriteReady
  );

  // Consumer side (TX buffer)
  modport slave (
    input  uartWriteReq,
    input  uartWriteData,
    output uartWriteReady
  );
endinterface

// File: rtl/uart_tx_buffer.sv
// UART transmit buffer: a FIFO of bytes written by the CPU, serialised onto the TX pin as
// 8N1 frames, LSB first. Back-to-back frames are sent with no idle gap between stop and start.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_buffer #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_AW      = 4
) (
  input  logic               clk,
  input  logic               reset,
  uart_tx_buffer_if.slave    wr_bus,
  output logic               txSerial,
  output logic               txBusy,
  output logic [FIFO_AW:0]   fifoCount
);

  localparam int unsigned Depth = 2 ** FIFO_AW;
  localparam int unsigned CntW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0]  CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0] CntFull = (FIFO_AW + 1)'(Depth);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               ready_q, ready_d;
  logic [7:0]         mem_q [Depth];
`ifdef UART_TX_PARITY_EN
  logic               par_q, par_d;
`endif

  logic       push;
  logic       pop;
  logic       baud_last;
  logic       fifo_nonempty;
  logic [7:0] head;

  assign push          = wr_bus.uartWriteReq && ready_q;
  assign baud_last     = (cnt_q == CntLast);
  // Pops only see bytes stored before this edge; a same-edge push waits one cycle.
  assign fifo_nonempty = (count_q != '0);
  assign head          = mem_q[rd_ptr_q];

  // Frame sequencer: next state, baud counter, bit index, shifter and pop request
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CntW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (fifo_nonempty) begin
          pop     = 1'b1;
          shift_d = head;
          bit_d   = 3'd0;
          state_d = StStart;
`ifdef UART_TX_PARITY_EN
          par_d   = ^head;
`endif
        end
      end
      StStart: begin
        if (baud_last) begin
          cnt_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (baud_last) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (baud_last) begin
          cnt_d   = '0;
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        if (baud_last) begin
          cnt_d = '0;
          // Chain straight into the next start bit when another byte is waiting.
          if (fifo_nonempty) begin
            pop     = 1'b1;
            shift_d = head;
            bit_d   = 3'd0;
            state_d = StStart;
`ifdef UART_TX_PARITY_EN
            par_d   = ^head;
`endif
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  // Line level is decoded from the next state so txSerial is a clean register output
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      StParity: tx_d = par_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  // FIFO pointer, occupancy and ready bookkeeping
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + (FIFO_AW + 1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (FIFO_AW + 1)'(1);
    end
    ready_d = (count_d != CntFull);
  end

  // State and control registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  // FIFO storage; contents need no reset since pointers gate every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_bus.uartWriteData;
    end
  end

  assign wr_bus.uartWriteReady = ready_q;
  assign txSerial              = tx_q;
  assign txBusy                = (state_q != StIdle);
  assign fifoCount             = count_q;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Self-checking bench for uart_tx_buffer: a queue-based frame model checked every cycle,
// plus directed scenarios with hand-computed waveform expectations.
module tb_uart_tx_buffer;

  localparam int unsigned Cpb   = 4;
  localparam int unsigned Aw    = 4;
  localparam int unsigned Depth = 16;
`ifdef UART_TX_PARITY_EN
  localparam int Frame = 11 * Cpb;
`else
  localparam int Frame = 10 * Cpb;
`endif

  logic          clk;
  logic          rst_n;
  logic          txSerial;
  logic          txBusy;
  logic [Aw:0]   fifoCount;

  uart_tx_buffer_if wr_if ();

  uart_tx_buffer #(
    .CLKS_PER_BIT (Cpb),
    .FIFO_AW      (Aw)
  ) dut (
    .clk       (clk),
    .reset     (rst_n),
    .wr_bus    (wr_if),
    .txSerial  (txSerial),
    .txBusy    (txBusy),
    .fifoCount (fifoCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // q: bytes waiting; w: per-cycle line levels still to be driven for frames already started.
  logic [7:0] q[$];
  logic       w[$];
  logic       exp_tx;
  logic       exp_busy;
  logic       exp_ready;
  int         exp_count;

  task automatic model_reset();
    q.delete();
    w.delete();
    exp_tx    = 1'b1;
    exp_busy  = 1'b0;
    exp_ready = 1'b1;
    exp_count = 0;
  endtask

  task automatic append_frame(input logic [7:0] b);
    logic bits [$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    bits.push_back(^b);
`endif
    bits.push_back(1'b1);
    foreach (bits[i]) for (int j = 0; j < int'(Cpb); j++) w.push_back(bits[i]);
  endtask

  task automatic model_step();
    logic       do_push;
    logic [7:0] d;
    do_push = wr_if.uartWriteReq && exp_ready;
    d       = wr_if.uartWriteData;
    if (w.size() == 0 && q.size() != 0) append_frame(q.pop_front());
    if (w.size() != 0) begin
      exp_tx   = w.pop_front();
      exp_busy = 1'b1;
    end else begin
      exp_tx   = 1'b1;
      exp_busy = 1'b0;
    end
    if (do_push) q.push_back(d);
    exp_count = q.size();
    exp_ready = (q.size() != Depth);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      check("txSerial", 32'(txSerial), 32'(exp_tx));
      check("txBusy", 32'(txBusy), 32'(exp_busy));
      check("uartWriteReady", 32'(wr_if.uartWriteReady), 32'(exp_ready));
      check("fifoCount", 32'(fifoCount), 32'(exp_count));
    end
  end

  // ---------------- directed stimulus ----------------
  logic smp [0:127];
  int   busy_cnt;

  task automatic record(input int n);
    busy_cnt = 0;
    for (int i = 0; i < n; i++) begin
      smp[i] = txSerial;
      busy_cnt += int'(txBusy);
      @(negedge clk);
    end
  endtask

  task automatic push_byte(input logic [7:0] d);
    @(negedge clk);
    wr_if.uartWriteReq  = 1'b1;
    wr_if.uartWriteData = d;
    @(negedge clk);
    wr_if.uartWriteReq  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [10:0] pat;
    int          nw;
    int          zeros;

    rst_n               = 1'b0;
    wr_if.uartWriteReq  = 1'b0;
    wr_if.uartWriteData = 8'h00;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;

    // 1: idle after reset
    repeat (100) @(negedge clk);
    check("idle_tx", 32'(txSerial), 32'd1);
    check("idle_ready", 32'(wr_if.uartWriteReady), 32'd1);
    check("idle_busy", 32'(txBusy), 32'd0);
    check("idle_count", 32'(fifoCount), 32'd0);

    // 2: single 0xA5 frame
    push_byte(8'hA5);
    @(negedge clk);
    record(48);
    pat = 11'b00_1101001010;
    for (int k = 0; k < 10; k++) check($sformatf("a5_bit%0d", k), 32'(smp[4*k+1]), 32'(pat[k]));
    check("a5_busy_cycles", 32'(busy_cnt), 32'(Frame));

    // 3: fill the FIFO, then hold a request while full
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      wr_if.uartWriteReq  = 1'b1;
      wr_if.uartWriteData = 8'(i);
    end
    @(negedge clk);
    wr_if.uartWriteData = 8'h11;
    check("full_count", 32'(fifoCount), 32'd16);
    check("full_ready", 32'(wr_if.uartWriteReady), 32'd0);
    nw = 0;
    while (wr_if.uartWriteReady !== 1'b1 && nw < 200) begin
      nw++;
      @(negedge clk);
    end
    check("full_wait_cycles", 32'(nw), 32'(Frame - 15));
    @(negedge clk);
    wr_if.uartWriteReq = 1'b0;
    nw = 0;
    while (!(txBusy == 1'b0 && fifoCount == '0) && nw < 1500) begin
      nw++;
      @(negedge clk);
    end
    check("drain_done", 32'(txBusy), 32'd0);

    // 4: back-to-back frames
    @(negedge clk);
    wr_if.uartWriteReq  = 1'b1;
    wr_if.uartWriteData = 8'h00;
    @(negedge clk);
    wr_if.uartWriteData = 8'hFF;
    @(negedge clk);
    wr_if.uartWriteReq  = 1'b0;
    record(2 * Frame + 8);
    check("b2b_busy_cycles", 32'(busy_cnt), 32'(2 * Frame));
    check("b2b_stop1", 32'(smp[Frame-1]), 32'd1);
    check("b2b_start2", 32'(smp[Frame]), 32'd0);
    check("b2b_data1", 32'(smp[5]), 32'd0);
    check("b2b_data2", 32'(smp[Frame+5]), 32'd1);

    // 5: asynchronous reset mid-frame
    @(negedge clk);
    wr_if.uartWriteReq  = 1'b1;
    wr_if.uartWriteData = 8'hA5;
    @(negedge clk);
    wr_if.uartWriteData = 8'h3C;
    @(negedge clk);
    wr_if.uartWriteReq  = 1'b0;
    repeat (17) @(negedge clk);
    check("pre_rst_tx", 32'(txSerial), 32'd0);
    check("pre_rst_count", 32'(fifoCount), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_tx", 32'(txSerial), 32'd1);
    check("rst_count", 32'(fifoCount), 32'd0);
    check("rst_busy", 32'(txBusy), 32'd0);
    check("rst_ready", 32'(wr_if.uartWriteReady), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    record(60);
    zeros = 0;
    for (int i = 0; i < 60; i++) zeros += int'(!smp[i]);
    check("post_rst_zeros", 32'(zeros), 32'd0);
    check("post_rst_busy", 32'(busy_cnt), 32'd0);

`ifdef UART_TX_PARITY_EN
    // 6: parity frame for 0x07
    push_byte(8'h07);
    @(negedge clk);
    record(50);
    pat = 11'b11000001110;
    for (int k = 0; k < 11; k++) check($sformatf("par_bit%0d", k), 32'(smp[4*k+1]), 32'(pat[k]));
    check("par_busy_cycles", 32'(busy_cnt), 32'd44);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
